// File: rtl/p2_max_stage.sv
// rtl/p2_max_stage.sv - per-sample unsigned max(A,B) with windowed running max, valid/ready pipelined
// Optional feature macro: P2_ARGMAX_EN adds the src_sel output (0 = A chosen incl. ties, 1 = B).
module p2_max_stage #(
  parameter int data_width = 8,
  parameter int WIN_LEN    = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [data_width-1:0] A,
  input  logic [data_width-1:0] B,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [data_width-1:0] max_out,
  output logic [data_width-1:0] win_max,
  output logic                  win_done,
  output logic [CNT_W-1:0]      sample_cnt
`ifdef P2_ARGMAX_EN
  ,
  output logic                  src_sel
`endif
);

  // Index of the final sample of a window.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  logic                  stall;
  logic                  s1_val;
  logic [data_width-1:0] s1_max;
  logic [CNT_W-1:0]      win_idx;
  logic [data_width-1:0] acc;
  logic [data_width-1:0] acc_next;

  // A held output beat freezes the whole pipeline and back-pressures the splitter.
  assign stall  = out_val & ~out_rdy;
  assign in_rdy = ~stall;

  // Running max including the sample in stage 1; index 0 starts a fresh window.
  always_comb begin
    acc_next = s1_max;
    if (win_idx != '0 && acc > s1_max) begin
      acc_next = acc;
    end
  end

  // Stage 1: register the larger field; ties select A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_val <= 1'b0;
      s1_max <= '0;
    end else if (!stall) begin
      if (in_val) begin
        s1_val <= 1'b1;
        s1_max <= (A >= B) ? A : B;
      end else begin
        s1_val <= 1'b0;
      end
    end
  end

  // Stage 2: present the sample and fold it into the current window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val    <= 1'b0;
      max_out    <= '0;
      win_max    <= '0;
      win_done   <= 1'b0;
      sample_cnt <= '0;
      win_idx    <= '0;
      acc        <= '0;
    end else if (!stall) begin
      out_val <= s1_val;
      if (s1_val) begin
        max_out    <= s1_max;
        sample_cnt <= win_idx;
        if (win_idx == LAST_IDX) begin
          win_max  <= acc_next;
          win_done <= 1'b1;
          win_idx  <= '0;
          acc      <= '0;
        end else begin
          win_done <= 1'b0;
          win_idx  <= win_idx + 1'b1;
          acc      <= acc_next;
        end
      end
    end
  end

`ifdef P2_ARGMAX_EN
  logic s1_sel;

  // Source select travels alongside the max value through both stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sel  <= 1'b0;
      src_sel <= 1'b0;
    end else if (!stall) begin
      if (in_val) begin
        s1_sel <= (B > A);
      end
      if (s1_val) begin
        src_sel <= s1_sel;
      end
    end
  end
`endif

endmodule

// File: tb/tb_p2_max_stage.sv
// tb/tb_p2_max_stage.sv - self-checking bench for p2_max_stage against a window-max reference model
module tb_p2_max_stage;
  localparam int DW = 8;
  localparam int WL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val;
  logic          in_rdy;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          out_val;
  logic          out_rdy;
  logic [DW-1:0] max_out;
  logic [DW-1:0] win_max;
  logic          win_done;
  logic [CW-1:0] sample_cnt;
  logic          sel_obs;
  logic          in_rdy1;
  logic          out_val1;
  logic [DW-1:0] max_out1;
  logic [DW-1:0] win_max1;
  logic          win_done1;
  logic [CW-1:0] sample_cnt1;

  always #5 clk = ~clk;

`ifdef P2_ARGMAX_EN
  logic src_sel;
  logic src_sel1;
  assign sel_obs = src_sel;
`else
  assign sel_obs = 1'b0;
`endif

  p2_max_stage #(.data_width(DW), .WIN_LEN(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .A(A), .B(B),
    .out_val(out_val), .out_rdy(out_rdy), .max_out(max_out), .win_max(win_max),
    .win_done(win_done), .sample_cnt(sample_cnt)
`ifdef P2_ARGMAX_EN
    , .src_sel(src_sel)
`endif
  );

  p2_max_stage #(.data_width(DW), .WIN_LEN(1), .CNT_W(CW)) dut_w1 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy1), .A(A), .B(B),
    .out_val(out_val1), .out_rdy(out_rdy), .max_out(max_out1), .win_max(win_max1),
    .win_done(win_done1), .sample_cnt(sample_cnt1)
`ifdef P2_ARGMAX_EN
    , .src_sel(src_sel1)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] mx;
    logic [CW-1:0] cnt;
    logic          done;
    logic [DW-1:0] wm;
    logic          sel;
  } beat_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] sa[$];
  logic [DW-1:0] sb[$];
  beat_t         got[$];
  beat_t         expq[$];
  logic [DW-1:0] stall_vals[$];
  int unstable, rdy_err, timeout, first_lat, w1_err, w1_beats;

  task automatic do_reset();
    rst = 1'b1; in_val = 1'b0; out_rdy = 1'b1; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Reference model: each accepted sample is max(A,B); every WL-th sample closes a window
  // whose maximum is taken over the last WL sample values.
  function automatic void build_exp();
    logic [DW-1:0] m[$];
    logic [DW-1:0] lastw;
    logic [DW-1:0] w;
    beat_t e;
    lastw = '0;
    expq.delete();
    for (int k = 0; k < sa.size(); k++) begin
      m.push_back((sa[k] >= sb[k]) ? sa[k] : sb[k]);
      e.mx   = m[k];
      e.cnt  = CW'(k % WL);
      e.done = ((k % WL) == WL - 1);
      if (e.done) begin
        w = '0;
        for (int j = k - WL + 1; j <= k; j++) if (m[j] > w) w = m[j];
        lastw = w;
      end
      e.wm = lastw;
`ifdef P2_ARGMAX_EN
      e.sel = (sb[k] > sa[k]);
`else
      e.sel = 1'b0;
`endif
      expq.push_back(e);
    end
  endfunction

  // Drives the stimulus list through the handshake and records what the DUT presents.
  task automatic run_list(input logic [31:0] bub_mask, input logic [31:0] stall_mask,
                          input int p_bub, input int p_stall);
    int ptr = 0;
    int c = 0;
    int t_in = -1;
    int idle = 0;
    bit prev_stall = 0;
    bit fin = 0;
    beat_t prev, cur;
    prev = '0;
    got.delete(); stall_vals.delete();
    unstable = 0; rdy_err = 0; timeout = 0; first_lat = -1; w1_err = 0; w1_beats = 0;
    while (!fin) begin
      @(posedge clk); #1;
      if (ptr < sa.size() && !(c < 32 && bub_mask[c]) && ($urandom_range(99) >= p_bub)) begin
        in_val = 1'b1; A = sa[ptr]; B = sb[ptr];
      end else begin
        in_val = 1'b0; A = DW'($urandom); B = DW'($urandom);
      end
      out_rdy = !(c < 32 && stall_mask[c]) && ($urandom_range(99) >= p_stall);
      @(negedge clk);
      cur.mx = max_out; cur.cnt = sample_cnt; cur.done = win_done; cur.wm = win_max; cur.sel = sel_obs;
      if (prev_stall && (!out_val || cur != prev)) unstable++;
      if (in_rdy !== !(out_val && !out_rdy)) rdy_err++;
      if (in_val && in_rdy) begin
        ptr++;
        if (t_in < 0) t_in = c;
      end
      if (out_val && first_lat < 0) first_lat = c - t_in;
      if (out_val && !out_rdy) stall_vals.push_back(max_out);
      if (out_val && out_rdy) got.push_back(cur);
      if (out_val1) begin
        w1_beats++;
        if (win_done1 !== 1'b1 || win_max1 !== max_out1 || max_out1 !== max_out) w1_err++;
      end
      prev_stall = out_val && !out_rdy;
      prev = cur;
      c++;
      if (ptr == sa.size() && got.size() >= sa.size()) idle++;
      if (idle >= 4) fin = 1;
      if (c > 400) begin timeout = 1; fin = 1; end
    end
    in_val = 1'b0; out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    in_val = 1'b1; A = 8'hAA; B = 8'h55; out_rdy = 1'b1; rst = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    @(negedge clk);
    n_checks++; if (out_val !== 1'b0) $display("FAIL reset_out_val: got %0d want 0", out_val); else n_pass++;
    n_checks++; if (win_done !== 1'b0) $display("FAIL reset_win_done: got %0d want 0", win_done); else n_pass++;
    n_checks++; if (max_out !== '0) $display("FAIL reset_max_out: got %0d want 0", max_out); else n_pass++;
    n_checks++; if (win_max !== '0) $display("FAIL reset_win_max: got %0d want 0", win_max); else n_pass++;
    n_checks++; if (sample_cnt !== '0) $display("FAIL reset_sample_cnt: got %0d want 0", sample_cnt); else n_pass++;
    n_checks++; if (in_rdy !== 1'b1) $display("FAIL reset_in_rdy: got %0d want 1", in_rdy); else n_pass++;
  endtask

  task automatic test_basic();
    logic [DW-1:0] em [4] = '{8'd9, 8'd12, 8'd7, 8'd1};
    do_reset();
    sa = '{8'd3, 8'd12, 8'd7, 8'd0};
    sb = '{8'd9, 8'd4, 8'd7, 8'd1};
    run_list(32'h0, 32'h0, 0, 0);
    n_checks++; if (timeout != 0) $display("FAIL basic_timeout: got %0d want 0", timeout); else n_pass++;
    n_checks++; if (first_lat != 2) $display("FAIL basic_latency: got %0d want 2", first_lat); else n_pass++;
    n_checks++; if (got.size() != 4) $display("FAIL basic_count: got %0d want 4", got.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++; if (got[i].mx !== em[i]) $display("FAIL basic_max[%0d]: got %0d want %0d", i, got[i].mx, em[i]); else n_pass++;
      n_checks++; if (got[i].cnt !== CW'(i)) $display("FAIL basic_cnt[%0d]: got %0d want %0d", i, got[i].cnt, i); else n_pass++;
      n_checks++; if (got[i].done !== (i == 3)) $display("FAIL basic_done[%0d]: got %0d want %0d", i, got[i].done, i == 3); else n_pass++;
    end
    n_checks++; if (got.size() == 4 && got[3].wm !== 8'd12) $display("FAIL basic_win_max: got %0d want 12", got[3].wm); else n_pass++;
    n_checks++; if (win_max !== 8'd12) $display("FAIL basic_win_max_hold: got %0d want 12", win_max); else n_pass++;
  endtask

  task automatic test_stall();
    logic [DW-1:0] em [4] = '{8'd9, 8'd12, 8'd7, 8'd1};
    do_reset();
    sa = '{8'd3, 8'd12, 8'd7, 8'd0};
    sb = '{8'd9, 8'd4, 8'd7, 8'd1};
    run_list(32'h0, 32'h1C, 0, 0);
    n_checks++; if (stall_vals.size() != 3) $display("FAIL stall_cycles: got %0d want 3", stall_vals.size()); else n_pass++;
    for (int i = 0; i < stall_vals.size(); i++) begin
      n_checks++; if (stall_vals[i] !== 8'd9) $display("FAIL stall_held_max[%0d]: got %0d want 9", i, stall_vals[i]); else n_pass++;
    end
    n_checks++; if (unstable != 0) $display("FAIL stall_stability: got %0d unstable beats want 0", unstable); else n_pass++;
    n_checks++; if (rdy_err != 0) $display("FAIL stall_in_rdy: got %0d bad cycles want 0", rdy_err); else n_pass++;
    n_checks++; if (got.size() != 4) $display("FAIL stall_count: got %0d want 4", got.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++; if (got[i].mx !== em[i] || got[i].cnt !== CW'(i)) $display("FAIL stall_seq[%0d]: got max %0d cnt %0d want max %0d cnt %0d", i, got[i].mx, got[i].cnt, em[i], i); else n_pass++;
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    sa = '{8'd5, 8'd1, 8'd15, 8'd3};
    sb = '{8'd0, 8'd2, 8'd0, 8'd8};
    build_exp();
    run_list(32'h56, 32'h0, 0, 0);
    n_checks++; if (got.size() != expq.size()) $display("FAIL bubble_count: got %0d want %0d", got.size(), expq.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_checks++; if (got[i] !== expq[i]) $display("FAIL bubble_beat[%0d]: got %h want %h", i, got[i], expq[i]); else n_pass++;
    end
    n_checks++; if (got.size() == 4 && (got[3].wm !== 8'd15 || got[3].done !== 1'b1)) $display("FAIL bubble_win_max: got %0d want 15", got[3].wm); else n_pass++;
  endtask

  task automatic test_two_windows();
    do_reset();
    sa = '{8'd1, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    sb = '{8'd0, 8'd2, 8'd3, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    build_exp();
    run_list(32'h0, 32'h0, 0, 0);
    n_checks++; if (got.size() != 8) $display("FAIL two_win_count: got %0d want 8", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_checks++; if (got[i] !== expq[i]) $display("FAIL two_win_beat[%0d]: got %h want %h", i, got[i], expq[i]); else n_pass++;
    end
    n_checks++; if (got.size() == 8 && got[3].wm !== 8'd4) $display("FAIL two_win_first: got %0d want 4", got[3].wm); else n_pass++;
    n_checks++; if (got.size() == 8 && got[7].wm !== 8'd0) $display("FAIL two_win_second: got %0d want 0", got[7].wm); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    sa = '{8'd9, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
    sb = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_list(32'h0, 32'h0, 0, 0);
    n_checks++; if (win_max !== 8'd9) $display("FAIL mid_pre_win_max: got %0d want 9", win_max); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (win_max !== '0 || sample_cnt !== '0 || out_val !== 1'b0) $display("FAIL mid_async_reset: got win_max %0d cnt %0d val %0d want 0 0 0", win_max, sample_cnt, out_val); else n_pass++;
    @(posedge clk); #2 rst = 1'b0;
    sa = '{8'd6, 8'd6, 8'd6, 8'd6};
    sb = '{8'd0, 8'd6, 8'd3, 8'd5};
    build_exp();
    run_list(32'h0, 32'h0, 0, 0);
    n_checks++; if (got.size() != 4) $display("FAIL mid_count: got %0d want 4", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      n_checks++; if (got[i] !== expq[i]) $display("FAIL mid_beat[%0d]: got %h want %h", i, got[i], expq[i]); else n_pass++;
    end
    n_checks++; if (got.size() == 4 && (got[3].wm !== 8'd6 || got[0].cnt !== '0)) $display("FAIL mid_restart: got wm %0d cnt0 %0d want 6 0", got[3].wm, got[0].cnt); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      sa.delete(); sb.delete();
      for (int k = 0; k < 22; k++) begin
        sa.push_back(DW'($urandom));
        sb.push_back(($urandom_range(3) == 0) ? sa[k] : DW'($urandom));
      end
      build_exp();
      run_list(32'h0, 32'h0, 30, 30);
      n_checks++; if (timeout != 0) $display("FAIL rand_timeout[%0d]: got %0d want 0", it, timeout); else n_pass++;
      n_checks++; if (got.size() != expq.size()) $display("FAIL rand_count[%0d]: got %0d want %0d", it, got.size(), expq.size()); else n_pass++;
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
        n_checks++; if (got[i] !== expq[i]) $display("FAIL rand_beat[%0d][%0d]: got %h want %h", it, i, got[i], expq[i]); else n_pass++;
      end
      n_checks++; if (unstable != 0) $display("FAIL rand_stability[%0d]: got %0d want 0", it, unstable); else n_pass++;
      n_checks++; if (rdy_err != 0) $display("FAIL rand_in_rdy[%0d]: got %0d want 0", it, rdy_err); else n_pass++;
      n_checks++; if (w1_err != 0 || w1_beats == 0) $display("FAIL rand_win1[%0d]: got %0d errors %0d beats want 0 errors", it, w1_err, w1_beats); else n_pass++;
    end
  endtask

`ifdef P2_ARGMAX_EN
  task automatic test_argmax();
    do_reset();
    sa = '{8'd5, 8'd1};
    sb = '{8'd5, 8'd8};
    run_list(32'h0, 32'h0, 0, 0);
    n_checks++; if (got.size() != 2) $display("FAIL argmax_count: got %0d want 2", got.size()); else n_pass++;
    n_checks++; if (got.size() == 2 && got[0].sel !== 1'b0) $display("FAIL argmax_tie: got %0d want 0", got[0].sel); else n_pass++;
    n_checks++; if (got.size() == 2 && got[1].sel !== 1'b1) $display("FAIL argmax_b: got %0d want 1", got[1].sel); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bubbles();
    test_two_windows();
    test_reset_mid();
    test_random();
`ifdef P2_ARGMAX_EN
    test_argmax();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/p2_max_stage.md
Name: p2_max_stage

Overview:
Second pipeline stage, directly downstream of the client-data splitter stage. Consumes the registered A and B fields and produces the per-sample unsigned maximum. Also tracks the running maximum over a fixed window of WIN_LEN samples. Uses a valid/ready handshake on both sides so the consumer can stall the pipeline.

Parameters:
data_width, 8, width of the A, B and max datapaths (unsigned)
WIN_LEN, 4, number of samples per max window; legal range 1..255
CNT_W, 8, width of the sample_cnt output; must satisfy 2^CNT_W >= WIN_LEN

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_val  in  1  A/B pair valid (driven by client_val delayed one cycle, aligned with the splitter's registered outputs)
in_rdy  out  1  stage can accept a pair this cycle
A  in  data_width  upper field from the splitter stage
B  in  data_width  lower field from the splitter stage (zero-extended nibble)
out_val  out  1  max_out valid
out_rdy  in  1  consumer accepts max_out this cycle
max_out  out  data_width  max(A,B) of the sample being presented
win_max  out  data_width  maximum over the most recently completed window
win_done  out  1  qualifies the current output beat as the last sample of a window
sample_cnt  out  CNT_W  index of the presented sample within its window, 0..WIN_LEN-1

Behaviour:
- Reset (async, rst=1):
  - s1_val, out_val, win_done = 0
  - max_out, win_max, sample_cnt = 0
  - internal window accumulator = 0
  - Any in-flight data is discarded; first accepted pair after reset starts window index 0.
- Stall rule: stall = out_val & ~out_rdy; in_rdy = ~stall. When stalled, every pipeline register holds.
- Input transfer: in_val & in_rdy. Output transfer: out_val & out_rdy.
- Stage 1 (compare): on input transfer, s1_max <= (A >= B) ? A : B, unsigned compare, and s1_val <= 1. If not stalled and no input transfer, s1_val <= 0.
- Stage 2 (output/window): when not stalled, out_val <= s1_val. If s1_val = 1, also:
  - max_out <= s1_max
  - sample_cnt <= current window index
  - acc_next = (index==0) ? s1_max : max(acc, s1_max)
  - if index == WIN_LEN-1: win_max <= acc_next, win_done <= 1, index wraps to 0, acc cleared
  - otherwise: win_done <= 0, index increments, acc <= acc_next
- Latency: 2 cycles from input transfer to out_val with no stall. Throughput: 1 pair per cycle.
- Stability: outputs stay stable while out_val & ~out_rdy. win_max holds between window completions; it updates on the same cycle win_done is raised.
- Boundaries:
  - Tie A == B: max_out = A.
  - WIN_LEN = 1: win_done = 1 on every beat, win_max = max_out.
  - Bubbles (in_val = 0) do not advance the window index.
  - Reset asserted mid-window abandons the partial window; win_max returns to 0.

Optional Feature:
Macro P2_ARGMAX_EN.
- Defined: adds output port src_sel (1 bit), valid with out_val. 0 = A was selected (including ties), 1 = B. It is pipelined alongside max_out and holds under stall. Reset value 0.
- Not defined: port absent, no added logic.

Test Plan:
- Reset, then pairs (A,B) = (3,9),(12,4),(7,7),(0,1) back-to-back, out_rdy=1 -> max_out 9,12,7,1 on cycles 2..5 after the first transfer; sample_cnt 0,1,2,3; win_done only on the 4th beat; win_max = 12 from that beat.
- Hold out_rdy=0 for 3 cycles while out_val=1 with max_out=9 -> in_rdy=0, max_out/sample_cnt stable; release -> sequence resumes with no loss or duplication.
- Insert in_val=0 bubbles between samples of a window -> sample_cnt unaffected by bubbles; win_done on the 4th valid sample; win_max correct (e.g. samples 5,2,15,8 give win_max = 15).
- Two windows: 1,2,3,4 then 0,0,0,0 -> win_max = 4 after window 1, then 0 after window 2 (no carry-over).
- Assert rst after 2 accepted samples, release, feed 4 samples 6,6,6,6 -> sample_cnt restarts at 0; win_max = 6 on the 4th beat.
- With P2_ARGMAX_EN: pairs (5,5),(1,8) -> src_sel 0, then 1. Build without the macro -> compiles, port absent.
